// File: rtl/unified_buffer_arbiter.sv
// Round-robin arbiter granting atomic bursts on the single-ported unified buffer.
// Optional macro UB_ARB_COMPUTE_PRIORITY_EN gives the compute read port (0) absolute priority.
module unified_buffer_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 256,
  parameter int LEN_W      = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            req_i,
  input  logic [3*ADDR_W-1:0]   addr_i,
  input  logic [3*LEN_W-1:0]    len_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  output logic [2:0]            gnt_o,
  output logic [2:0]            beat_o,
  output logic [2:0]            done_o,
  output logic                  ub_en_o,
  output logic                  ub_we_o,
  output logic [ADDR_W-1:0]     ub_addr_o,
  output logic [DATA_W-1:0]     ub_wdata_o,
  output logic                  rd_valid_o
);

  typedef enum logic [1:0] {IDLE, TURNAROUND, BURST} state_t;

  state_t            state_reg;
  logic [1:0]        ptr_reg;
  logic              prev_wr_reg;
  logic [ADDR_W-1:0] start_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  beat_cnt_reg;
  logic [2:0]        gnt_reg, beat_reg, done_reg;
  logic              en_reg, we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rv_pipe_reg [RD_LATENCY];

  logic [ADDR_W-1:0] addr_port [3];
  logic [LEN_W-1:0]  len_port  [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_port
      assign addr_port[gi] = addr_i[gi*ADDR_W +: ADDR_W];
      assign len_port[gi]  = len_i[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Winner selection; ptr_reg names the port searched first.
  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] ptr_next;

  always_comb begin
    int c;
    c         = 0;
    win_valid = 1'b0;
    win_idx   = 2'd0;
`ifdef UB_ARB_COMPUTE_PRIORITY_EN
    if (req_i[0]) begin
      win_valid = 1'b1;
      win_idx   = 2'd0;
    end else if (ptr_reg == 2'd2) begin
      if (req_i[2])      begin win_valid = 1'b1; win_idx = 2'd2; end
      else if (req_i[1]) begin win_valid = 1'b1; win_idx = 2'd1; end
    end else begin
      if (req_i[1])      begin win_valid = 1'b1; win_idx = 2'd1; end
      else if (req_i[2]) begin win_valid = 1'b1; win_idx = 2'd2; end
    end
    if (win_idx == 2'd0)      ptr_next = ptr_reg;
    else if (win_idx == 2'd1) ptr_next = 2'd2;
    else                      ptr_next = 2'd0;
`else
    // Scan downward so the closest requesting port to the pointer wins last.
    for (int k = 2; k >= 0; k--) begin
      c = int'(ptr_reg) + k;
      if (c >= 3) c = c - 3;
      if (req_i[c[1:0]]) begin
        win_valid = 1'b1;
        win_idx   = c[1:0];
      end
    end
    ptr_next = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      prev_wr_reg  <= 1'b0;
      start_reg    <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      gnt_reg      <= 3'b000;
      beat_reg     <= 3'b000;
      done_reg     <= 3'b000;
      en_reg       <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
    end else begin
      done_reg <= 3'b000;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            start_reg    <= addr_port[win_idx];
            len_reg      <= len_port[win_idx];
            beat_cnt_reg <= '0;
            gnt_reg      <= 3'b001 << win_idx;
            ptr_reg      <= ptr_next;
            prev_wr_reg  <= (win_idx != 2'd0);
            // A read following a write needs one bubble on the shared bus.
            if (win_idx == 2'd0 && prev_wr_reg) begin
              state_reg <= TURNAROUND;
            end else begin
              state_reg <= BURST;
              beat_reg  <= 3'b001 << win_idx;
              en_reg    <= 1'b1;
              we_reg    <= (win_idx != 2'd0);
              addr_reg  <= addr_port[win_idx];
            end
          end
        end
        TURNAROUND: begin
          state_reg <= BURST;
          beat_reg  <= 3'b001;
          en_reg    <= 1'b1;
          we_reg    <= 1'b0;
          addr_reg  <= start_reg;
        end
        BURST: begin
          if (beat_cnt_reg == len_reg) begin
            state_reg <= IDLE;
            done_reg  <= gnt_reg;
            gnt_reg   <= 3'b000;
            beat_reg  <= 3'b000;
            en_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
            addr_reg     <= start_reg + ADDR_W'(beat_cnt_reg + LEN_W'(1));
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_rv
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) rv_pipe_reg[gi] <= 1'b0;
          else       rv_pipe_reg[gi] <= beat_reg[0];
        end
      end else begin : g_tail
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) rv_pipe_reg[gi] <= 1'b0;
          else       rv_pipe_reg[gi] <= rv_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign gnt_o      = gnt_reg;
  assign beat_o     = beat_reg;
  assign done_o     = done_reg;
  assign ub_en_o    = en_reg;
  assign ub_we_o    = we_reg;
  assign ub_addr_o  = addr_reg;
  assign rd_valid_o = rv_pipe_reg[RD_LATENCY-1];
  assign ub_wdata_o = gnt_reg[2] ? wdata_i[2*DATA_W-1:DATA_W] :
                      gnt_reg[1] ? wdata_i[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_unified_buffer_arbiter.sv
// Self-checking bench for unified_buffer_arbiter: directed scenarios plus a
// randomized run against a burst-schedule reference model.
`timescale 1ns/1ps
module tb_unified_buffer_arbiter;
  localparam int AW = 12, DW = 256, LW = 10, RDL = 2, NCYC = 600;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req;
  logic [3*AW-1:0] addr;
  logic [3*LW-1:0] len;
  logic [2*DW-1:0] wdata;
  logic [2:0]      gnt, beat, done;
  logic            en, we, rv;
  logic [AW-1:0]   ua;
  logic [DW-1:0]   uwd;
  logic [23:0]     obs;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  unified_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LATENCY(RDL)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .len_i(len), .wdata_i(wdata),
    .gnt_o(gnt), .beat_o(beat), .done_o(done), .ub_en_o(en), .ub_we_o(we),
    .ub_addr_o(ua), .ub_wdata_o(uwd), .rd_valid_o(rv)
  );

  // {gnt, beat, done, en, we, addr, rd_valid}
  assign obs = {gnt, beat, done, en, we, ua, rv};

  function automatic logic [23:0] mk(input logic [2:0] g, input logic [2:0] b, input logic [2:0] d,
                                     input logic e, input logic w, input logic [AW-1:0] a, input logic r);
    return {g, b, d, e, w, a, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input int l);
    addr[p*AW +: AW] = a;
    len[p*LW +: LW]  = LW'(l);
  endtask

  task automatic do_reset;
    rst = 1'b1; req = 3'b000; addr = '0; len = '0; wdata = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 3'b000; addr = '0; len = '0; wdata = '1;
    #1;
    n_tests++;
    if (obs !== 24'h0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", obs); end
    n_tests++;
    if (uwd !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h want=0", uwd); end
    tick; tick;
    rst = 1'b0; wdata = '0;
    tick;
    n_tests++;
    if (obs !== 24'h0) begin n_fail++; $display("FAIL reset_idle got=%h want=0", obs); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_compute_read;
    logic [23:0] e;
    do_reset;
    set_port(0, 12'h040, 31); req = 3'b001;
    tick; req = 3'b000;
    for (int c = 0; c < 36; c++) begin
      if (c <= 31)      e = mk(3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 12'(32'h40 + c), 1'b0);
      else if (c == 32) e = mk(3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 12'h0, 1'b0);
      else              e = 24'h0;
      e[0] = (c >= RDL && c <= 31 + RDL);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL compute_read c=%0d got=%h want=%h", c, obs, e); end
      tick;
    end
    $display("[TB] test_compute_read done");
  endtask

  task automatic test_write_then_read;
    logic [23:0] e;
    logic [DW-1:0] wd;
    do_reset;
    set_port(1, 12'h010, 3); req = 3'b010;
    tick;
    set_port(0, 12'h100, 1); req = 3'b001;
    for (int c = 0; c < 10; c++) begin
      wd = {8{$urandom}};
      wdata[DW-1:0] = wd;
      #1;
      case (c)
        0, 1, 2, 3: e = mk(3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 12'(32'h10 + c), 1'b0);
        4:          e = mk(3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 12'h0, 1'b0);
        5:          e = mk(3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 12'h0, 1'b0);
        6, 7:       e = mk(3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 12'(32'h100 + c - 6), 1'b0);
        8:          e = mk(3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 12'h0, 1'b1);
        9:          e = mk(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 12'h0, 1'b1);
        default:    e = 24'h0;
      endcase
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL write_then_read c=%0d got=%h want=%h", c, obs, e); end
      if (c <= 3) begin
        n_tests++;
        if (uwd !== wd) begin n_fail++; $display("FAIL write_data c=%0d got=%h want=%h", c, uwd, wd); end
      end
      if (c == 5) req = 3'b000;
      tick;
    end
    $display("[TB] test_write_then_read done");
  endtask

  task automatic test_round_robin;
    int got [6];
    int want [6];
    int ng = 0;
    logic [2:0] prev = 3'b000;
    do_reset;
    for (int p = 0; p < 3; p++) set_port(p, 12'(p * 256), 0);
    req = 3'b111;
`ifdef UB_ARB_COMPUTE_PRIORITY_EN
    want = '{0, 0, 0, 1, 2, 1};
`else
    want = '{0, 1, 2, 0, 1, 2};
`endif
    for (int c = 0; c < 80 && ng < 6; c++) begin
      tick;
      if (gnt != 3'b000 && prev == 3'b000) begin
        got[ng] = gnt[2] ? 2 : (gnt[1] ? 1 : 0);
        ng++;
`ifdef UB_ARB_COMPUTE_PRIORITY_EN
        if (ng == 3) req[0] = 1'b0;
`endif
      end
      prev = gnt;
    end
    req = 3'b000;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (i >= ng) begin n_fail++; $display("FAIL round_robin grant %0d missing want port %0d", i, want[i]); end
      else if (got[i] !== want[i]) begin
        n_fail++; $display("FAIL round_robin grant %0d got port %0d want port %0d", i, got[i], want[i]);
      end
    end
    $display("[TB] test_round_robin done");
  endtask

  task automatic test_wrap;
    logic [23:0] e;
    logic [DW-1:0] wd;
    logic [AW-1:0] exp_addr [4];
    exp_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    do_reset;
    set_port(2, 12'hFFE, 3); req = 3'b100;
    tick; req = 3'b000;
    for (int c = 0; c < 6; c++) begin
      wd = {8{$urandom}};
      wdata[2*DW-1:DW] = wd;
      #1;
      if (c <= 3)      e = mk(3'b100, 3'b100, 3'b000, 1'b1, 1'b1, exp_addr[c], 1'b0);
      else if (c == 4) e = mk(3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 12'h0, 1'b0);
      else             e = 24'h0;
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL wrap c=%0d got=%h want=%h", c, obs, e); end
      if (c <= 3) begin
        n_tests++;
        if (uwd !== wd) begin n_fail++; $display("FAIL wrap_wdata c=%0d got=%h want=%h", c, uwd, wd); end
      end
      tick;
    end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_reset_mid_burst;
    logic [23:0] e;
    do_reset;
    set_port(0, 12'h200, 15); req = 3'b001;
    tick;
    repeat (5) tick;
    e = mk(3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 12'h205, 1'b1);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midburst_beat5 got=%h want=%h", obs, e); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== 24'h0) begin n_fail++; $display("FAIL midburst_async_clear got=%h want=0", obs); end
    for (int c = 0; c < 2; c++) begin
      tick;
      n_tests++;
      if (obs !== 24'h0) begin n_fail++; $display("FAIL midburst_in_reset c=%0d got=%h want=0", c, obs); end
    end
    set_port(0, 12'h300, 15);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      e = mk(3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 12'(32'h300 + c), c >= RDL);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL midburst_restart c=%0d got=%h want=%h", c, obs, e); end
    end
    req = 3'b000;
    $display("[TB] test_reset_mid_burst done");
  endtask

  task automatic test_req_drop;
    logic [23:0] e;
    do_reset;
    set_port(1, 12'h020, 7); req = 3'b010;
    tick;
    for (int c = 0; c < 10; c++) begin
      if (c <= 7)      e = mk(3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 12'(32'h20 + c), 1'b0);
      else if (c == 8) e = mk(3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 12'h0, 1'b0);
      else             e = 24'h0;
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL req_drop c=%0d got=%h want=%h", c, obs, e); end
      if (c == 2) req = 3'b000;
      tick;
    end
    $display("[TB] test_req_drop done");
  endtask

  // Reference model: at each free arbitration edge it schedules the whole burst
  // (grant window, beats, done pulse, read-valid echoes) into per-cycle tables.
  task automatic test_random;
    logic [23:0] ex [NCYC+64];
    logic [2:0] pend = 3'b000;
    int free_e = 0, rr = 0, w, d, l;
    bit last_wr = 1'b0;
    logic [AW-1:0] a0;
    int errs = 0;
    do_reset;
    foreach (ex[i]) ex[i] = 24'h0;
    for (int e = 0; e < NCYC; e++) begin
      @(posedge clk);
      if (e >= free_e && req != 3'b000) begin
        w = -1;
`ifdef UB_ARB_COMPUTE_PRIORITY_EN
        if (req[0])       w = 0;
        else if (rr == 2) w = req[2] ? 2 : 1;
        else              w = req[1] ? 1 : 2;
`else
        for (int k = 0; k < 3; k++) if (w < 0 && req[(rr + k) % 3]) w = (rr + k) % 3;
`endif
        d  = (w == 0 && last_wr) ? 1 : 0;
        l  = int'(len[w*LW +: LW]);
        a0 = addr[w*AW +: AW];
        for (int j = 0; j <= d + l; j++) ex[e+j][23:21] = 3'b001 << w;
        for (int k = 0; k <= l; k++) begin
          ex[e+d+k][20:18] = 3'b001 << w;
          ex[e+d+k][14]    = 1'b1;
          ex[e+d+k][13]    = (w != 0);
          ex[e+d+k][12:1]  = 12'(a0 + 12'(k));
          if (w == 0) ex[e+d+k+RDL][0] = 1'b1;
        end
        ex[e+d+l+1][17:15] = 3'b001 << w;
        free_e  = e + d + l + 2;
        last_wr = (w != 0);
`ifdef UB_ARB_COMPUTE_PRIORITY_EN
        if (w != 0) rr = (w + 1) % 3;
`else
        rr = (w + 1) % 3;
`endif
        pend[w] = 1'b0;
      end
      #1;
      n_tests++;
      if (obs !== ex[e]) begin
        n_fail++; errs++;
        if (errs <= 10) $display("FAIL random e=%0d got=%h want=%h", e, obs, ex[e]);
      end
      for (int p = 0; p < 3; p++) begin
        if (!pend[p] && $urandom_range(0, 3) == 0) begin
          pend[p] = 1'b1;
          set_port(p, 12'($urandom), int'($urandom_range(0, 4)));
        end
      end
      req = pend;
    end
    req = 3'b000;
    $display("[TB] test_random done, %0d cycles", NCYC);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_compute_read;
    test_write_then_read;
    test_round_robin;
    test_wrap;
    test_reset_mid_burst;
    test_req_drop;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
